ram_scan_ctrl: RTL and testbench

// - Address/write controller feeding the 32x4 single-port RAM on the DE1 board; owns the RAM's address, data, wren.
// - Sweeps read addresses 0..31 (one word per tick) and publishes each word for the HEX displays.
// - Interleaves single-cycle user writes requested by an edge on a filtered switch/key level.
// - Sits downstream of the metastability filters and upstream of the RAM and the seg7 decoders.

---
 rtl/ram_scan_pkg.sv | 9 +
 rtl/ram_scan_ctrl_if.sv | 33 +++
 rtl/scan_tick_gen.sv | 28 ++
 rtl/ram_scan_ctrl.sv | 107 ++++++++++
 tb/tb_ram_scan_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_scan_pkg.sv
// Shared FSM state type and default RAM geometry for the DE1 32x4 RAM scan controller.
package ram_scan_pkg;

  typedef enum logic [1:0] {SCAN, WRITE, RD_WAIT} scan_state_t;

  localparam int RAM_ADDR_W = 5;
  localparam int RAM_DATA_W = 4;

endpackage

// File: rtl/ram_scan_ctrl_if.sv
// Bundle of user-write, RAM and display signals around ram_scan_ctrl; master = controller side.
interface ram_scan_ctrl_if
  import ram_scan_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DATA_W = RAM_DATA_W
) ();

  // No backpressure anywhere: wr_req is a level whose 0->1 edge requests one write,
  // ram_wren is a one-cycle command, scan_valid is a one-cycle strobe with no ready.
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_data;
  logic              ram_wren;
  logic [DATA_W-1:0] ram_q;
  logic [ADDR_W-1:0] scan_addr;
  logic [DATA_W-1:0] scan_data;
  logic              scan_valid;
  scan_state_t       dbg_state;

  modport master (
    input  wr_req, wr_addr, wr_data, ram_q,
    output ram_addr, ram_data, ram_wren, scan_addr, scan_data, scan_valid, dbg_state
  );

  modport slave (
    output wr_req, wr_addr, wr_data, ram_q,
    input  ram_addr, ram_data, ram_wren, scan_addr, scan_data, scan_valid, dbg_state
  );

endinterface

// File: rtl/scan_tick_gen.sv
// Free-running divider: one-cycle tick every TICK_CYCLES enabled clocks; holds while en=0.
module scan_tick_gen #(
  parameter int TICK_CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en) cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/ram_scan_ctrl.sv
// Scan/write controller for the 32x4 single-port RAM: sweeps reads for the HEX display, interleaves user writes.
// Optional RAM_SCAN_PAUSE_EN adds a pause input that freezes the scan tick.
module ram_scan_ctrl
  import ram_scan_pkg::*;
#(
  parameter int ADDR_W      = RAM_ADDR_W,
  parameter int DATA_W      = RAM_DATA_W,
  parameter int TICK_CYCLES = 50_000_000,
  parameter int RD_LATENCY  = 2
) (
  input  logic           clk,
  input  logic           reset_n,
`ifdef RAM_SCAN_PAUSE_EN
  input  logic           pause,
`endif
  ram_scan_ctrl_if.master bus
);

  localparam logic [1:0] LAT_LAST = 2'(RD_LATENCY - 1);

  scan_state_t       state_q;
  logic [ADDR_W-1:0] rd_ptr_q;
  logic [ADDR_W-1:0] scan_addr_q;
  logic [DATA_W-1:0] scan_data_q;
  logic              scan_valid_q;
  logic              wr_pend_q;
  logic              rd_pend_q;
  logic              prev_req_q;
  logic [1:0]        wait_q;
  logic              tick_en;
  logic              tick;
  logic              wr_edge;

`ifdef RAM_SCAN_PAUSE_EN
  assign tick_en = ~pause;
`else
  assign tick_en = 1'b1;
`endif

  scan_tick_gen #(.TICK_CYCLES(TICK_CYCLES)) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (tick_en),
    .tick    (tick)
  );

  assign wr_edge = bus.wr_req & ~prev_req_q;

  // Later assignments win: a tick on the launch cycle re-arms rd_pend, while an
  // edge landing in the WRITE cycle merges into the write being issued.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= SCAN;
      rd_ptr_q     <= '0;
      scan_addr_q  <= '0;
      scan_data_q  <= '0;
      scan_valid_q <= 1'b0;
      wr_pend_q    <= 1'b0;
      rd_pend_q    <= 1'b0;
      prev_req_q   <= 1'b0;
      wait_q       <= '0;
    end else begin
      prev_req_q   <= bus.wr_req;
      scan_valid_q <= 1'b0;
      if (tick)    rd_pend_q <= 1'b1;
      if (wr_edge) wr_pend_q <= 1'b1;
      case (state_q)
        SCAN: begin
          if (wr_pend_q) begin
            state_q <= WRITE;
          end else if (rd_pend_q) begin
            rd_pend_q <= tick;
            wait_q    <= '0;
            state_q   <= RD_WAIT;
          end
        end
        WRITE: begin
          wr_pend_q <= 1'b0;
          state_q   <= SCAN;
        end
        RD_WAIT: begin
          if (wait_q == LAT_LAST) begin
            scan_data_q  <= bus.ram_q;
            scan_addr_q  <= rd_ptr_q;
            scan_valid_q <= 1'b1;
            rd_ptr_q     <= rd_ptr_q + 1'b1;
            state_q      <= SCAN;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        default: state_q <= SCAN;
      endcase
    end
  end

  // RAM controls decode straight from registered state so the read address is
  // already on the RAM during the launch cycle and wr_addr/wr_data are taken in WRITE.
  assign bus.ram_wren   = (state_q == WRITE);
  assign bus.ram_addr   = (state_q == WRITE) ? bus.wr_addr : rd_ptr_q;
  assign bus.ram_data   = (state_q == WRITE) ? bus.wr_data : '0;
  assign bus.scan_addr  = scan_addr_q;
  assign bus.scan_data  = scan_data_q;
  assign bus.scan_valid = scan_valid_q;
  assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_ram_scan_ctrl.sv
// Self-checking bench for ram_scan_ctrl with a latency-2 RAM model (TICK_CYCLES=4, RD_LATENCY=2).
module tb_ram_scan_ctrl;
  import ram_scan_pkg::*;

  localparam int AW = 5;
  localparam int DW = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
`ifdef RAM_SCAN_PAUSE_EN
  logic pause = 1'b0;
`endif

  int total = 0;
  int bad = 0;
  logic [AW-1:0]    exp_ptr = '0;
  logic [AW+DW-1:0] exp_q[$];
  logic [DW-1:0]    shadow[32];

  always #5 clk = ~clk;

  ram_scan_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bif ();

  ram_scan_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TICK_CYCLES(4), .RD_LATENCY(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
`ifdef RAM_SCAN_PAUSE_EN
    .pause   (pause),
`endif
    .bus     (bif)
  );

  function automatic logic [DW-1:0] pat(input int i);
    return DW'((i * 7 + 3) % 16);
  endfunction

  // RAM model: registered address and registered output, contents survive reset
  logic [DW-1:0] ram_mem[32];
  logic [DW-1:0] q1, q2;
  logic ram_loaded = 1'b0;
  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < 32; i++) ram_mem[i] <= pat(i);
      ram_loaded <= 1'b1;
    end else if (bif.ram_wren) begin
      ram_mem[bif.ram_addr] <= bif.ram_data;
    end
    q1 <= ram_mem[bif.ram_addr];
    q2 <= q1;
  end
  assign bif.ram_q = q2;

  task automatic monitor();
    logic [AW+DW-1:0] e;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        exp_ptr = '0;
      end else begin
        total++;
        if (bif.ram_wren) begin
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_write: got addr=%h data=%h, required no write", bif.ram_addr, bif.ram_data);
          end else begin
            e = exp_q.pop_front();
            if ({bif.ram_addr, bif.ram_data} !== e) begin
              bad++;
              $display("FAIL write_word: got addr=%h data=%h, required addr=%h data=%h",
                       bif.ram_addr, bif.ram_data, e[AW+DW-1:DW], e[DW-1:0]);
            end
          end
        end else if (bif.ram_data !== '0) begin
          bad++;
          $display("FAIL idle_ram_data: got %h, required 0", bif.ram_data);
        end
        if (bif.scan_valid) begin
          total++;
          if (bif.scan_addr !== exp_ptr || bif.scan_data !== shadow[exp_ptr]) begin
            bad++;
            $display("FAIL scan_word: got addr=%0d data=%h, required addr=%0d data=%h",
                     bif.scan_addr, bif.scan_data, exp_ptr, shadow[exp_ptr]);
          end
          exp_ptr = exp_ptr + 1'b1;
        end
      end
    end
  endtask

  task automatic wait_valid(input int max_cyc, output int n);
    n = -1;
    for (int i = 1; i <= max_cyc; i++) begin
      @(negedge clk);
      if (bif.scan_valid) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic wait_state(input scan_state_t s, input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(posedge clk);
      #1;
      if (bif.dbg_state == s) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_addr(input logic [AW-1:0] a, output bit ok);
    int n;
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      wait_valid(12, n);
      if (n < 0) break;
      if (bif.scan_addr == a) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [19:0] v;
    int n;
    reset_n = 1'b0;
    bif.wr_req = 1'b0;
    bif.wr_addr = '0;
    bif.wr_data = '0;
    repeat (3) @(negedge clk);
    v = {bif.ram_addr, bif.ram_data, bif.ram_wren, bif.scan_addr, bif.scan_data, bif.scan_valid};
    total++;
    if (v !== '0) begin bad++; $display("FAIL reset_outputs: got %h, required 0", v); end
    reset_n = 1'b1;
    wait_valid(20, n);
    total++;
    if (n !== 7) begin bad++; $display("FAIL first_valid_latency: got %0d, required 7", n); end
    total++;
    if (bif.scan_addr !== 5'd0) begin bad++; $display("FAIL first_scan_addr: got %0d, required 0", bif.scan_addr); end
    for (int k = 1; k <= 3; k++) begin
      wait_valid(10, n);
      total++;
      if (n !== 4) begin bad++; $display("FAIL valid_interval: got %0d, required 4", n); end
      total++;
      if (bif.scan_addr !== AW'(k)) begin bad++; $display("FAIL scan_seq: got %0d, required %0d", bif.scan_addr, k); end
    end
  endtask

  task automatic test_write_collision();
    int n, wren_idx, wren_cnt, val_idx;
    bit ok;
    wait_valid(12, n);
    total++;
    if (n < 0) begin bad++; $display("FAIL coll_sync: got timeout, required scan_valid"); end
    bif.wr_addr = 5'h0A;
    bif.wr_data = 4'hA;
    bif.wr_req = 1'b1;
    exp_q.push_back({5'h0A, 4'hA});
    shadow[10] = 4'hA;
    wren_idx = -1; wren_cnt = 0; val_idx = -1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 1) bif.wr_req = 1'b0;
      if (bif.ram_wren) begin
        wren_cnt++;
        if (wren_idx < 0) wren_idx = i;
      end
      if (bif.scan_valid && val_idx < 0) val_idx = i;
    end
    total++;
    if (wren_idx !== 2) begin bad++; $display("FAIL coll_write_cycle: got %0d, required 2", wren_idx); end
    total++;
    if (wren_cnt !== 1) begin bad++; $display("FAIL coll_write_count: got %0d, required 1", wren_cnt); end
    total++;
    if (val_idx !== 6) begin bad++; $display("FAIL coll_read_after_write: got %0d, required 6", val_idx); end
    wait_addr(5'h0A, ok);
    total++;
    if (!ok || bif.scan_data !== 4'hA) begin
      bad++; $display("FAIL written_word_scanned: got found=%0d data=%h, required found=1 data=a", ok, bif.scan_data);
    end
  endtask

  task automatic test_wrap();
    int n;
    bit ok;
    wait_addr(5'd31, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL wrap_reach_31: got timeout, required addr 31"); end
    wait_valid(12, n);
    total++;
    if (n !== 4 || bif.scan_addr !== 5'd0) begin
      bad++; $display("FAIL wrap_to_zero: got n=%0d addr=%0d, required n=4 addr=0", n, bif.scan_addr);
    end
  endtask

  task automatic test_merge();
    logic req_pat[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    int n, wren_idx, wren_cnt;
    bit ok;
    repeat (2) wait_valid(12, n);
    total++;
    if (n < 0) begin bad++; $display("FAIL merge_sync: got timeout, required scan_valid"); end
    exp_q.push_back({5'h15, 4'hC});
    shadow[5'h15] = 4'hC;
    wren_idx = -1; wren_cnt = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk);
      #1;
      bif.wr_req = req_pat[i-1];
      if (i >= 5)      begin bif.wr_addr = 5'h15; bif.wr_data = 4'hC; end
      else if (i >= 3) begin bif.wr_addr = 5'h07; bif.wr_data = 4'h7; end
      else             begin bif.wr_addr = 5'h03; bif.wr_data = 4'h3; end
      @(negedge clk);
      if (bif.ram_wren) begin
        wren_cnt++;
        if (wren_idx < 0) wren_idx = i;
      end
    end
    total++;
    if (wren_cnt !== 1) begin bad++; $display("FAIL merge_write_count: got %0d, required 1", wren_cnt); end
    total++;
    if (wren_idx !== 5) begin bad++; $display("FAIL merge_write_cycle: got %0d, required 5", wren_idx); end
    wait_addr(5'h15, ok);
    total++;
    if (!ok || bif.scan_data !== 4'hC) begin
      bad++; $display("FAIL merge_word_scanned: got found=%0d data=%h, required found=1 data=c", ok, bif.scan_data);
    end
  endtask

  task automatic test_random_writes();
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      a = exp_ptr + 5'd16 + AW'($urandom_range(0, 7));
      d = DW'($urandom_range(0, 15));
      bif.wr_addr = a;
      bif.wr_data = d;
      bif.wr_req = 1'b1;
      exp_q.push_back({a, d});
      shadow[a] = d;
      @(posedge clk);
      #1;
      bif.wr_req = 1'b0;
      repeat ($urandom_range(6, 10)) @(posedge clk);
    end
    repeat (6) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL random_writes_drained: got %0d left, required 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    logic [19:0] v;
    int n;
    bit ok;
    @(posedge clk);
    #1;
    bif.wr_addr = 5'h02;
    bif.wr_data = 4'hF;
    bif.wr_req = 1'b1;
    wait_state(WRITE, 12, ok);
    reset_n = 1'b0;
    bif.wr_req = 1'b0;
    #1;
    v = {bif.ram_addr, bif.ram_data, bif.ram_wren, bif.scan_addr, bif.scan_data, bif.scan_valid};
    total++;
    if (!ok || v !== '0) begin bad++; $display("FAIL reset_in_write: got found=%0d outputs=%h, required found=1 outputs=0", ok, v); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    wait_valid(20, n);
    total++;
    if (n !== 7 || bif.scan_addr !== 5'd0) begin
      bad++; $display("FAIL restart_after_write_abort: got n=%0d addr=%0d, required n=7 addr=0", n, bif.scan_addr);
    end
    wait_addr(5'h02, ok);
    total++;
    if (!ok || bif.scan_data !== pat(2)) begin
      bad++; $display("FAIL aborted_write_absent: got found=%0d data=%h, required found=1 data=%h", ok, bif.scan_data, pat(2));
    end
    wait_state(RD_WAIT, 12, ok);
    reset_n = 1'b0;
    #1;
    v = {bif.ram_addr, bif.ram_data, bif.ram_wren, bif.scan_addr, bif.scan_data, bif.scan_valid};
    total++;
    if (!ok || v !== '0) begin bad++; $display("FAIL reset_in_rd_wait: got found=%0d outputs=%h, required found=1 outputs=0", ok, v); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    wait_valid(20, n);
    total++;
    if (n !== 7 || bif.scan_addr !== 5'd0) begin
      bad++; $display("FAIL restart_after_read_abort: got n=%0d addr=%0d, required n=7 addr=0", n, bif.scan_addr);
    end
  endtask

`ifdef RAM_SCAN_PAUSE_EN
  task automatic test_pause();
    int n, vcnt, wcnt;
    wait_valid(12, n);
    pause = 1'b1;
    bif.wr_addr = exp_ptr + 5'd20;
    bif.wr_data = 4'h6;
    bif.wr_req = 1'b1;
    exp_q.push_back({bif.wr_addr, 4'h6});
    shadow[bif.wr_addr] = 4'h6;
    vcnt = 0; wcnt = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 2) bif.wr_req = 1'b0;
      if (bif.scan_valid) vcnt++;
      if (bif.ram_wren) wcnt++;
    end
    pause = 1'b0;
    total++;
    if (vcnt !== 0) begin bad++; $display("FAIL pause_no_scan: got %0d pulses, required 0", vcnt); end
    total++;
    if (wcnt !== 1) begin bad++; $display("FAIL pause_write_serviced: got %0d writes, required 1", wcnt); end
    wait_valid(12, n);
    total++;
    if (n < 0) begin bad++; $display("FAIL pause_resume: got timeout, required scan_valid"); end
  endtask
`endif

  initial begin
    for (int i = 0; i < 32; i++) shadow[i] = pat(i);
    fork
      monitor();
    join_none
    test_reset();
    test_write_collision();
    test_wrap();
    test_merge();
    test_random_writes();
    test_reset_mid();
`ifdef RAM_SCAN_PAUSE_EN
    test_pause();
`endif
    repeat (8) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL writes_outstanding: got %0d, required 0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
